i2c_slave: RTL and testbench

I2C target (slave) endpoint for the 100 kHz I2C bus driven by the team's `i2c_master`. It is the other end of that protocol: it detects START and STOP, matches a 7-bit address, and ACKs. Write bytes are delivered to local logic; bytes for master reads are fetched from local logic. SCL and SDA are oversampled on the system clock; SDA is open-drain, and the block never drives SCL (no clock stretching).

---
 rtl/i2c_slave.sv | 198 +++++++++++++++++++
 tb/tb_i2c_slave.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// I2C target endpoint: oversampled SCL/SDA, 7-bit address match, ACK generation,
// write bytes delivered to local logic, read bytes fetched from local logic.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [7:0] r_rx_data, w_rx_data_nxt;
  logic       r_rx_valid, w_rx_valid_nxt;
  logic       r_sda_out, w_sda_out_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_rw, w_rw_nxt;
  logic       r_phase, w_phase_nxt;
  logic       w_tx_req;

  logic r_scl_s1, r_scl_s2, r_scl_s3;
  logic r_sda_s1, r_sda_s2, r_sda_s3;

  // Open-drain: only ever pull low, otherwise release to the bus pull-up.
  assign sda = r_sda_out ? 1'b0 : 1'bz;

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = r_scl_s2 & ~r_scl_s3;
  assign w_scl_fall = ~r_scl_s2 & r_scl_s3;
  assign w_start    = r_scl_s2 & r_scl_s3 & r_sda_s3 & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_s3 & ~r_sda_s3 & r_sda_s2;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_sda_out_nxt  = r_sda_out;
    w_busy_nxt     = r_busy;
    w_rw_nxt       = r_rw;
    w_phase_nxt    = r_phase;
    w_tx_req       = 1'b0;

    if (w_start) begin
      w_state_nxt   = ADDR;
      w_bit_cnt_nxt = 3'd0;
      w_sda_out_nxt = 1'b0;
      w_busy_nxt    = 1'b0;
      w_phase_nxt   = 1'b0;
    end else if (w_stop) begin
      w_state_nxt   = IDLE;
      w_sda_out_nxt = 1'b0;
      w_busy_nxt    = 1'b0;
      w_phase_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: ;
        ADDR: if (w_scl_rise) begin
          w_shift_nxt   = {r_shift[6:0], r_sda_s2};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            if (r_shift[6:0] == SLAVE_ADDR) begin
              w_rw_nxt    = r_sda_s2;
              w_phase_nxt = 1'b0;
              w_state_nxt = ADDR_ACK;
            end else begin
              w_state_nxt = IDLE;
            end
          end
        end
        // phase 0: waiting to assert ACK; phase 1: ACK held, next fall ends the slot
        ADDR_ACK: if (w_scl_fall) begin
          if (!r_phase) begin
            w_sda_out_nxt = 1'b1;
            w_busy_nxt    = 1'b1;
            w_phase_nxt   = 1'b1;
          end else begin
            w_phase_nxt = 1'b0;
            if (r_rw) begin
              w_tx_req      = 1'b1;
              w_shift_nxt   = tx_data;
              w_sda_out_nxt = ~tx_data[7];
              w_state_nxt   = RD_BYTE;
            end else begin
              w_sda_out_nxt = 1'b0;
              w_state_nxt   = WR_BYTE;
            end
          end
        end
        WR_BYTE: if (w_scl_rise) begin
          w_shift_nxt   = {r_shift[6:0], r_sda_s2};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_rx_data_nxt  = {r_shift[6:0], r_sda_s2};
            w_rx_valid_nxt = 1'b1;
            w_phase_nxt    = 1'b0;
            w_state_nxt    = WR_ACK;
          end
        end
        WR_ACK: if (w_scl_fall) begin
          if (!r_phase) begin
            w_sda_out_nxt = 1'b1;
            w_phase_nxt   = 1'b1;
          end else begin
            w_sda_out_nxt = 1'b0;
            w_phase_nxt   = 1'b0;
            w_state_nxt   = WR_BYTE;
          end
        end
        // The MSB is already on the bus; each fall presents the next bit.
        RD_BYTE: if (w_scl_fall) begin
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_sda_out_nxt = 1'b0;
            w_phase_nxt   = 1'b0;
            w_state_nxt   = RD_ACK;
          end else begin
            w_shift_nxt   = {r_shift[6:0], 1'b0};
            w_sda_out_nxt = ~r_shift[6];
          end
        end
        RD_ACK: begin
          if (w_scl_rise) begin
            if (r_sda_s2) begin
              w_busy_nxt  = 1'b0;
              w_state_nxt = IDLE;
            end else begin
              w_phase_nxt = 1'b1;
            end
          end else if (w_scl_fall && r_phase) begin
            w_tx_req      = 1'b1;
            w_shift_nxt   = tx_data;
            w_sda_out_nxt = ~tx_data[7];
            w_phase_nxt   = 1'b0;
            w_state_nxt   = RD_BYTE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      r_scl_s1   <= 1'b1;
      r_scl_s2   <= 1'b1;
      r_scl_s3   <= 1'b1;
      r_sda_s1   <= 1'b1;
      r_sda_s2   <= 1'b1;
      r_sda_s3   <= 1'b1;
      r_state    <= IDLE;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_sda_out  <= 1'b0;
      r_busy     <= 1'b0;
      r_rw       <= 1'b0;
      r_phase    <= 1'b0;
    end else begin
      r_scl_s1   <= scl;
      r_scl_s2   <= r_scl_s1;
      r_scl_s3   <= r_scl_s2;
      r_sda_s1   <= sda;
      r_sda_s2   <= r_sda_s1;
      r_sda_s3   <= r_sda_s2;
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_sda_out  <= w_sda_out_nxt;
      r_busy     <= w_busy_nxt;
      r_rw       <= w_rw_nxt;
      r_phase    <= w_phase_nxt;
    end
  end

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign tx_req   = w_tx_req;
  assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: the bench acts as bus master and compares
// observed bus/local behaviour with a transaction-level reference model.
module tb_i2c_slave;

  localparam logic [6:0] SLAVE = 7'h42;
  localparam int Q = 5;  // quarter SCL period in clk cycles (20x oversampling)

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, busy;
  wire        sda_bus;

  assign sda_bus = m_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_slave #(.SLAVE_ADDR(SLAVE)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda_bus),
    .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_req(tx_req), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] rx_q[$];
  int txreq_cnt = 0;
  int slave_low_cnt = 0;
  logic [7:0] wdat[4];
  logic [7:0] rdat[4];

  // Monitors of the local interface and of target-driven SDA.
  always @(negedge clk) begin
    if (rx_valid) rx_q.push_back(rx_data);
    if (tx_req) txreq_cnt++;
    if (sda_bus === 1'b0 && !m_low) slave_low_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_tx(input logic b, output logic s);
    wait_clk(Q);
    m_low = ~b;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    s = sda_bus;
    wait_clk(Q);
    scl = 1'b0;
  endtask

  task automatic bus_start();
    m_low = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    m_low = 1'b1;
    wait_clk(Q);
    scl = 1'b0;
  endtask

  task automatic bus_stop();
    m_low = 1'b1;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    m_low = 1'b0;
    wait_clk(2 * Q);
  endtask

  // Returns 1 when the target pulled SDA low in the ninth slot.
  task automatic byte_wr(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_tx(d[i], s);
    bit_tx(1'b1, s);
    ack = ~s;
  endtask

  task automatic run_write(input logic [6:0] a, input int n);
    logic ack;
    logic match;
    match = (a == SLAVE);
    rx_q.delete();
    slave_low_cnt = 0;
    bus_start();
    byte_wr({a, 1'b0}, ack);
    check("wr_addr_ack", ack, match);
    check("wr_busy_after_addr", busy, match);
    for (int i = 0; i < n; i++) begin
      byte_wr(wdat[i], ack);
      check("wr_data_ack", ack, match);
    end
    bus_stop();
    check("wr_busy_after_stop", busy, 1'b0);
    check("wr_rx_count", rx_q.size(), match ? n : 0);
    for (int i = 0; i < n && i < rx_q.size(); i++) check("wr_rx_data", rx_q[i], wdat[i]);
    if (!match) check("wr_never_driven", slave_low_cnt, 0);
  endtask

  task automatic run_read(input logic [6:0] a, input int n);
    logic ack, s;
    logic match;
    logic [7:0] d;
    match = (a == SLAVE);
    txreq_cnt = 0;
    tx_data = rdat[0];
    bus_start();
    byte_wr({a, 1'b1}, ack);
    check("rd_addr_ack", ack, match);
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        bit_tx(1'b1, s);
        d = {d[6:0], s};
      end
      check("rd_data", d, match ? rdat[i] : 8'hFF);
      if (i + 1 < n) tx_data = rdat[i + 1];
      bit_tx((i + 1 < n) ? 1'b0 : 1'b1, s);
    end
    wait_clk(2 * Q);
    check("rd_sda_released", sda_bus, 1'b1);
    check("rd_busy_after_nack", busy, 1'b0);
    bus_stop();
    check("rd_txreq_count", txreq_cnt, match ? n : 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic ack, s;
    logic [6:0] a;
    int n;

    wait_clk(4);
    reset = 1'b0;
    wait_clk(2);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_tx_req", tx_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sda", sda_bus, 1'b1);

    // Directed write and address mismatch.
    wdat[0] = 8'hA5; wdat[1] = 8'h3C;
    run_write(SLAVE, 2);
    wdat[0] = 8'hFF;
    run_write(7'h43, 1);

    // Directed read, master ACKs first byte and NACKs the second.
    rdat[0] = 8'h96; rdat[1] = 8'h5A;
    run_read(SLAVE, 2);

    // Repeated START: write one byte, then read one byte.
    rx_q.delete();
    txreq_cnt = 0;
    bus_start();
    byte_wr({SLAVE, 1'b0}, ack);
    byte_wr(8'h10, ack);
    check("sr_wr_ack", ack, 1'b1);
    tx_data = 8'hC3;
    bus_start();
    byte_wr({SLAVE, 1'b1}, ack);
    check("sr_addr_ack", ack, 1'b1);
    for (int b = 7; b >= 0; b--) begin
      bit_tx(1'b1, s);
      check("sr_rd_bit", s, (8'hC3 >> b) & 8'h01);
    end
    bit_tx(1'b1, s);
    bus_stop();
    check("sr_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("sr_rx_data", rx_q[0], 8'h10);
    check("sr_txreq_count", txreq_cnt, 1);

    // Abort mid-byte with STOP.
    rx_q.delete();
    bus_start();
    byte_wr({SLAVE, 1'b0}, ack);
    for (int b = 0; b < 4; b++) bit_tx(b[0], s);
    bus_stop();
    check("abort_rx_count", rx_q.size(), 0);
    check("abort_busy", busy, 1'b0);
    check("abort_sda", sda_bus, 1'b1);

    // Reset while the target drives a 0 bit of a read byte.
    tx_data = 8'h96;
    bus_start();
    byte_wr({SLAVE, 1'b1}, ack);
    bit_tx(1'b1, s);
    check("rst_rd_msb", s, 1'b1);
    wait_clk(Q);
    check("rst_rd_bit_low", sda_bus, 1'b0);
    reset = 1'b1;
    wait_clk(1);
    check("midrst_sda", sda_bus, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rx_valid", rx_valid, 1'b0);
    check("midrst_tx_req", tx_req, 1'b0);
    check("midrst_rx_data", rx_data, 8'h00);
    reset = 1'b0;
    slave_low_cnt = 0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(2 * Q);
    scl = 1'b0;
    for (int b = 0; b < 7; b++) bit_tx(1'b1, s);
    bus_stop();
    check("postrst_never_driven", slave_low_cnt, 0);
    wdat[0] = 8'h5E;
    run_write(SLAVE, 1);

    // Randomized transactions against the model.
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 1) a = SLAVE;
      else begin
        a = 7'($urandom_range(0, 127));
        if (a == SLAVE) a = a + 7'd1;
      end
      n = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) begin
        wdat[i] = 8'($urandom);
        rdat[i] = 8'($urandom);
      end
      if ($urandom_range(0, 1) == 1) run_write(a, n);
      else run_read(a, n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
